// File: rtl/dly_pkg.sv
// rtl/dly_pkg.sv - width helpers and state encoding for the programmable delay line
package dly_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width needed to hold 0..max_dly inclusive.
    function automatic int dly_width(input int max_dly);
        return (clog2(max_dly + 1) < 1) ? 1 : clog2(max_dly + 1);
    endfunction

    // Ring address width; a single-entry ring still needs one address bit.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FILL = 1'b1
    } dly_state_e;

endpackage

// File: rtl/dl_ring_ram.sv
// rtl/dl_ring_ram.sv - simple dual-port ring storage, synchronous write, asynchronous read
module dl_ring_ram
    import dly_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees the old word when rd_addr == wr_addr, which is what a full-depth delay needs.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - runtime-programmable delay of a sample stream and its valid flag
module prog_delay_line
    import dly_pkg::*;
#(
    parameter int REFCLK_F = 50,
    parameter int DOUT_W   = 8,
    parameter int MAX_DLY  = 16,
    localparam int DLY_W   = dly_width(MAX_DLY)
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic [DOUT_W-1:0] din,
    input  logic              din_vld,
    input  logic [DLY_W-1:0]  dly_cfg,
    input  logic              cfg_we,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              cfg_err
);

    localparam int AW = addr_width(MAX_DLY);
    localparam int RW = DOUT_W + 1;
    localparam int CW = DLY_W + 1;

    if (REFCLK_F < 1) begin : g_bad_refclk
        $error("prog_delay_line: REFCLK_F must be >= 1");
    end
    if (DOUT_W < 1) begin : g_bad_dout_w
        $error("prog_delay_line: DOUT_W must be >= 1");
    end
    if (MAX_DLY < 1) begin : g_bad_max_dly
        $error("prog_delay_line: MAX_DLY must be >= 1");
    end

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    wptr_nxt;
    logic [AW-1:0]    rd_addr;
    logic [DLY_W-1:0] dly_cur;
    logic [DLY_W-1:0] fill_cnt;
    logic [DLY_W-1:0] fill_nxt;
    logic [CW-1:0]    wptr_ext;
    logic [CW-1:0]    dly_ext;
    logic [CW-1:0]    rd_diff;
    logic [RW-1:0]    wr_word;
    logic [RW-1:0]    rd_word;
    logic [RW-1:0]    sel_word;
    logic             cfg_over;
    logic             cfg_load;
    logic             fill_ok;
    dly_state_e       state;

    assign wr_word  = {din_vld, din};
    assign cfg_over = (int'(dly_cfg) > MAX_DLY);
    assign cfg_load = cfg_we & ~cfg_over;
    assign fill_ok  = (fill_cnt >= dly_cur);

    assign wptr_nxt = (wptr == AW'(MAX_DLY - 1)) ? '0 : wptr + AW'(1);
    assign fill_nxt = (fill_cnt == DLY_W'(MAX_DLY)) ? fill_cnt : fill_cnt + DLY_W'(1);

    // Modular subtraction done with an explicit wrap so MAX_DLY need not be a power of two.
    assign wptr_ext = CW'(wptr);
    assign dly_ext  = CW'(dly_cur);
    always_comb begin
        rd_diff = '0;
        if (wptr_ext >= dly_ext) begin
            rd_diff = wptr_ext - dly_ext;
        end else begin
            rd_diff = wptr_ext + CW'(MAX_DLY) - dly_ext;
        end
    end
    assign rd_addr = rd_diff[AW-1:0];

    dl_ring_ram #(
        .DEPTH (MAX_DLY),
        .WIDTH (RW)
    ) u_ring (
        .clk     (ref_clk),
        .wr_en   (1'b1),
        .wr_addr (wptr),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // Zero delay bypasses the ring so latency stays at the single output register.
    assign sel_word = (dly_cur == '0) ? wr_word : rd_word;

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            dly_cur  <= '0;
            fill_cnt <= '0;
            state    <= ST_RUN;
            dout     <= '0;
            dout_vld <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            dout     <= sel_word[DOUT_W-1:0];
            dout_vld <= sel_word[DOUT_W] & fill_ok;
            cfg_err  <= cfg_we & cfg_over;
            if (cfg_load) begin
                // The sample written on this edge stays outside the new history.
                dly_cur  <= dly_cfg;
                fill_cnt <= '0;
                state    <= (dly_cfg != '0) ? ST_FILL : ST_RUN;
            end else begin
                fill_cnt <= fill_nxt;
                case (state)
                    ST_FILL: begin
                        if (fill_nxt >= dly_cur) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        state <= ST_RUN;
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_FILL);

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
Parametrised programmable delay line; next generation of the fixed single-output delay top.
- Delays a DOUT_W-wide sample stream plus its valid flag by a runtime-selectable number of ref_clk cycles, 0..MAX_DLY.
- Uses a ring buffer and fill gating; output is never valid with stale or mixed-history data.
- Sits between a sample source and downstream alignment logic in the ref_clk domain.

Parameters:
- REFCLK_F, 50: reference clock frequency in MHz. Informational only; used by the bench for time reporting.
- DOUT_W, 8: sample width in bits, ≥1.
- MAX_DLY, 16: maximum programmable delay in cycles, ≥1. Need not be a power of 2.
- DLY_W, clog2(MAX_DLY+1): derived localparam, not overridable. Width of dly_cfg.

Ports:
- ref_clk, input, 1: sole clock. All logic on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- din, input, DOUT_W: input sample.
- din_vld, input, 1: din qualifier. Bubbles are stored and delayed like data.
- dly_cfg, input, DLY_W: requested delay in cycles.
- cfg_we, input, 1: one-cycle strobe that loads dly_cfg.
- dout, output, DOUT_W: delayed sample, registered.
- dout_vld, output, 1: delayed qualifier, registered.
- busy, output, 1: high while the buffer refills after a delay change.
- cfg_err, output, 1: one-cycle pulse when dly_cfg > MAX_DLY.

Behaviour:
- **Reset.** Asynchronous assertion clears the following, with no clock needed:
  - dout=0, dout_vld=0, busy=0, cfg_err=0
  - dly_cur=0, wptr=0, fill_cnt=0
  - Ring RAM contents are not reset; fill gating masks them.
- **Ring buffer.** Depth MAX_DLY entries of {din_vld, din}.
  - Written every cycle at wptr.
  - wptr increments modulo MAX_DLY with explicit wrap (MAX_DLY-1 → 0).
- **Transfer function.** Let x(t) = {din_vld, din} sampled at edge t. Then dout/dout_vld(t+1) = x(t − dly_cur).
  - Total latency is dly_cur+1 cycles.
  - dly_cur=0 reads the live input through a bypass mux, giving 1-cycle latency.
  - Read address = (wptr − dly_cur) mod MAX_DLY, computed without a power-of-2 assumption.
- **Fill gating.** fill_cnt counts samples written since the last flush and saturates at MAX_DLY.
  - dout_vld(t+1) = stored_vld AND (fill_cnt(t) ≥ dly_cur).
  - dout still updates while gated; its value is don't-care when dout_vld=0.
- **State machine.** Two states:
  - FILL: busy=1. Active while fill_cnt < dly_cur.
  - RUN: busy=0. Entered when fill_cnt reaches dly_cur.
  - busy is decoded from registered state.
- **Config, valid value.** cfg_we=1 at edge t with dly_cfg ≤ MAX_DLY:
  - dly_cur=dly_cfg from t+1, and fill_cnt=0 at t+1.
  - State goes to FILL if dly_cfg>0, otherwise RUN.
  - Writing the current value still flushes.
  - cfg_we during FILL restarts the fill.
- **Config, invalid value.** cfg_we=1 with dly_cfg > MAX_DLY:
  - Ignored: no dly_cur change, no flush.
  - cfg_err=1 for exactly cycle t+1.
- **Simultaneous cfg_we and din_vld.** The sample at edge t is written. It belongs to the pre-flush history and is never output under the new delay.
- **Reset mid-operation.** Outputs drop immediately. On release, operation resumes at dly=0.

Decomposition:
- Package dly_pkg holds the clog2 function and the DLY_W derivation helper.
- Natural sub-module: dl_ring_ram, a simple dual-port RAM.
  - Parameters: DEPTH, WIDTH.
  - Synchronous write, asynchronous read.
  - Maps to distributed RAM.
- The top holds the pointers, fill counter, FSM and output register.

Test Plan:
1. Reset release with dly=0; drive din=1,2,3,… with din_vld=1 → dout equals the previous cycle's din; dout_vld=1 from the first cycle after the first sample.
2. cfg_we at cycle 10 with dly_cfg=5; ramp din from cycle 11 → busy=1 for cycles 11–15; dout_vld=0 until cycle 17; dout at cycle 17 equals the cycle-11 sample; latency 6 thereafter.
3. MAX_DLY=16 and also MAX_DLY=12 (non-power-of-2), dly=MAX_DLY, 50-sample ramp → latency MAX_DLY+1 throughout wrap, no skipped or repeated values.
4. dly=5 running, cfg_we with dly_cfg=17 (MAX_DLY=16) → cfg_err=1 for one cycle; dly_cur stays 5; busy stays 0; stream uninterrupted.
5. dly=3; din_vld pattern 1,0,1,1,0 → identical dout_vld pattern 4 cycles later, with matching data on valid cycles.
6. Assert reset mid-stream at dly=7 → dout=0, dout_vld=0, busy=0 immediately; after release the stream has 1-cycle latency.
